branch_resolve_ctrl: RTL
========================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sits directly downstream of the branch condition handler. It takes the handler's
//  br_taken output together with the decoded control-transfer instruction (CTI) in ID.
//  It resolves SPARC delayed-branch semantics (delay slot, annul bit, BA/BN, CALL, JMPL).
//  It drives the fetch redirect and the delay-slot squash, and keeps saturating branch
//  statistics counters.
// PARAMETERS
//  ADDR_W  32  width of PC / target addresses
//  CNT_W   16  width of each statistics counter
// PORTS
//  clk          in   1       pipeline clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  stall        in   1       pipeline hold; freezes FSM, outputs and counters
//  id_valid     in   1       ID-stage instruction is valid (not a bubble/squashed)
//  id_is_bicc   in   1       ID holds a Bicc
//  id_is_call   in   1       ID holds CALL
//  id_is_jmpl   in   1       ID holds JMPL
//  id_a         in   1       annul bit of the Bicc
//  id_cond      in   4       cond field of the Bicc (1000=BA, 0000=BN)
//  br_taken     in   1       condition-handler result for id_cond
//  br_target    in   ADDR_W  PC+disp target (Bicc/CALL)
//  jmpl_target  in   ADDR_W  rs1+op2 target (JMPL)
//  redirect     out  1       fetch must load target as next nPC
//  target       out  ADDR_W  redirect address
//  annul_ds     out  1       squash the instruction now in ID (delay slot)
//  dcti_err     out  1       a CTI was found in a delay slot (1-cycle pulse)
//  br_cnt       out  CNT_W   resolved Bicc count
//  taken_cnt    out  CNT_W   taken Bicc count
//  annul_cnt    out  CNT_W   annulled delay-slot count
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; redirect=0, target=0, annul_ds=0, dcti_err=0,
//   all counters=0. Reset mid-DS discards the pending redirect and squash.
//  cti = id_valid & (id_is_bicc|id_is_call|id_is_jmpl). The ID-type inputs are one-hot;
//   priority on violation is jmpl>call>bicc.
//  FSM states: IDLE, DS.
//   IDLE, ~stall & cti at edge T -> DS. At T the CTI is in ID and its delay slot is in IF.
//   DS lasts exactly one unstalled cycle (T+1); delay slot is in ID -> IDLE on next ~stall edge.
//   stall=1 in any state: state, outputs and counters hold unchanged.
//  Decision at T, outputs registered, so they are valid during T+1 (latency 1):
//   take   = call | jmpl | (bicc & br_taken)
//   annul  = bicc & id_a & (~br_taken | id_cond==4'b1000)   (BA,a and BN,a annul too)
//   redirect=take; target = jmpl ? jmpl_target : br_target (0 when ~take); annul_ds=annul.
//  In DS the outputs are asserted for exactly one unstalled cycle, then drop to 0 in IDLE.
//  DCTI couple: cti seen while state=DS (delay slot is itself a CTI):
//   - it is not resolved and causes no redirect and no counter updates;
//   - dcti_err=1 for the following cycle;
//   - FSM still returns to IDLE.
//   If annul_ds=1 in that cycle, the squashed CTI is ignored silently (no dcti_err).
//  Counters advance only on resolve edges (IDLE, ~stall, cti). They saturate at all-ones
//   and never wrap.
//   br_cnt+=bicc; taken_cnt+=bicc&br_taken; annul_cnt+=annul. CALL/JMPL do not count.
//  id_valid=0 never changes state or counters. br_taken is ignored unless bicc.
// TESTING
//  1 BNE a=0, br_taken=1, br_target=0x100 -> T+1 redirect=1 target=0x100 annul_ds=0;
//    br_cnt=1 taken_cnt=1.
//  2 BE a=1, br_taken=0 -> T+1 redirect=0 target=0 annul_ds=1; annul_cnt=1 taken_cnt=0.
//  3 BA a=1, br_taken=1, br_target=0x40 -> redirect=1 target=0x40 annul_ds=1.
//    JMPL jmpl_target=0x2000 -> redirect=1 target=0x2000, br_cnt unchanged.
//  4 CALL, then CALL in delay slot -> one redirect only; dcti_err=1 one cycle; back to IDLE.
//    Stall 3 cycles in DS -> redirect held 3 cycles, then exactly 1 more cycle.
//  5 Preload-free: 2^CNT_W+2 taken Bicc -> taken_cnt=all-ones.
//    rst_n=0 asynchronously mid-DS -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Purpose : resolves SPARC delayed control transfers (Bicc/CALL/JMPL) from ID into a fetch
//           redirect and delay-slot squash; flags DCTI couples; keeps saturating branch statistics.
// Latency : 1 cycle, because decisions made at the resolve edge are registered and valid the next cycle.
// Backpr. : stall freezes the FSM, all registered outputs and the counters; there is no other flow control.
// Ports   : clk/rst_n (async active-low); stall; ID decode (id_valid, id_is_*, id_a, id_cond);
//           br_taken, br_target, jmpl_target in; redirect/target/annul_ds/dcti_err and
//           br_cnt/taken_cnt/annul_cnt out.
module branch_resolve_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              id_valid,
  input  logic              id_is_bicc,
  input  logic              id_is_call,
  input  logic              id_is_jmpl,
  input  logic              id_a,
  input  logic [3:0]        id_cond,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic [ADDR_W-1:0] jmpl_target,
  output logic              redirect,
  output logic [ADDR_W-1:0] target,
  output logic              annul_ds,
  output logic              dcti_err,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  annul_cnt
);

  typedef enum logic {
    S_IDLE = 1'b0,  // no CTI in flight
    S_DS   = 1'b1   // previous unstalled edge resolved a CTI; its delay slot is now in ID
  } state_t;

  state_t state_q, state_d;

  logic              redirect_q, redirect_d;
  logic [ADDR_W-1:0] target_q,   target_d;
  logic              annul_q,    annul_d;
  logic              dcti_q,     dcti_d;
  logic [CNT_W-1:0]  br_cnt_q,    br_cnt_d;
  logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0]  annul_cnt_q, annul_cnt_d;

  // Type decode: inputs should be one-hot, but if several are set JMPL wins, then CALL.
  logic sel_jmpl, sel_call, sel_bicc;
  logic cti, take, annul, resolve;

  assign sel_jmpl = id_is_jmpl;
  assign sel_call = id_is_call & ~id_is_jmpl;
  assign sel_bicc = id_is_bicc & ~id_is_call & ~id_is_jmpl;
  assign cti      = id_valid & (id_is_bicc | id_is_call | id_is_jmpl);

  assign take     = cti & (sel_call | sel_jmpl | (sel_bicc & br_taken));
  // BA,a annuls even though taken; BN,a annuls because it is never taken.
  assign annul    = cti & sel_bicc & id_a & (~br_taken | (id_cond == 4'b1000));
  assign resolve  = (state_q == S_IDLE) & ~stall & cti;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        S_IDLE:  if (cti) state_d = S_DS;
        S_DS:    state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output / counter next-values. Everything holds under stall; otherwise the
  // redirect/squash pulse lives for exactly one unstalled cycle.
  always_comb begin
    redirect_d  = redirect_q;
    target_d    = target_q;
    annul_d     = annul_q;
    dcti_d      = dcti_q;
    br_cnt_d    = br_cnt_q;
    taken_cnt_d = taken_cnt_q;
    annul_cnt_d = annul_cnt_q;
    if (!stall) begin
      redirect_d = 1'b0;
      target_d   = '0;
      annul_d    = 1'b0;
      dcti_d     = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cti) begin
            redirect_d = take;
            target_d   = take ? (sel_jmpl ? jmpl_target : br_target) : '0;
            annul_d    = annul;
          end
        end
        S_DS: begin
          // A CTI sitting in a delay slot is an error unless that slot is being squashed.
          dcti_d = cti & ~annul_q;
        end
        default: ;
      endcase
    end
    if (resolve) begin
      br_cnt_d    = sat_inc(br_cnt_q,    sel_bicc);
      taken_cnt_d = sat_inc(taken_cnt_q, sel_bicc & br_taken);
      annul_cnt_d = sat_inc(annul_cnt_q, annul);
    end
  end

  // Output / counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q  <= 1'b0;
      target_q    <= '0;
      annul_q     <= 1'b0;
      dcti_q      <= 1'b0;
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
      annul_cnt_q <= '0;
    end else begin
      redirect_q  <= redirect_d;
      target_q    <= target_d;
      annul_q     <= annul_d;
      dcti_q      <= dcti_d;
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
      annul_cnt_q <= annul_cnt_d;
    end
  end

  assign redirect  = redirect_q;
  assign target    = target_q;
  assign annul_ds  = annul_q;
  assign dcti_err  = dcti_q;
  assign br_cnt    = br_cnt_q;
  assign taken_cnt = taken_cnt_q;
  assign annul_cnt = annul_cnt_q;

endmodule
